// File: rtl/issue_scheduler_pkg.sv
// Shared types and sizing for the issue scheduler and its entry selector.
package issue_scheduler_pkg;

    localparam int RS_DEPTH = 16;
    localparam int RS_IDX_W = 4;
    localparam int NUM_FU   = 3;

    // Functional-unit codes carried per RS entry; code 3 is reserved and never matches an FU.
    typedef enum logic [1:0] {
        FU_ALU0 = 2'd0,
        FU_ALU1 = 2'd1,
        FU_MEM  = 2'd2
    } fu_e;

endpackage

// File: rtl/issue_scheduler_oldest_select.sv
// Picks one candidate entry out of the RS candidate vector.
// ISSUE_AGE_ORDER_EN defined : oldest candidate relative to rob_head wins.
// ISSUE_AGE_ORDER_EN undefined: lowest-index candidate wins and rob_head is ignored.
module oldest_select
    import issue_scheduler_pkg::*;
(
    input  logic [RS_DEPTH-1:0] cand,
    input  logic [RS_IDX_W-1:0] rob_head,
    output logic                found,
    output logic [RS_IDX_W-1:0] idx
);

`ifdef ISSUE_AGE_ORDER_EN
    logic [RS_IDX_W-1:0] w_pos;

    // Walk ages from youngest to oldest so the last hit is the minimum age.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int k = RS_DEPTH - 1; k >= 0; k--) begin
            w_pos = rob_head + RS_IDX_W'(k);
            if (cand[w_pos]) begin
                found = 1'b1;
                idx   = w_pos;
            end
        end
    end
`else
    logic w_unused_rob_head;
    assign w_unused_rob_head = ^rob_head;

    // Walk indices from high to low so the last hit is the lowest index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = RS_DEPTH - 1; k >= 0; k--) begin
            if (cand[k]) begin
                found = 1'b1;
                idx   = RS_IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/issue_scheduler.sv
// Per-cycle issue scheduler: one pick per FU (ALU0, ALU1, MEM) from the RS,
// registered issue slot per FU under valid/ready, and in-flight bookkeeping.
// Pick order is selected by the ISSUE_AGE_ORDER_EN macro (see oldest_select).
module issue_scheduler
    import issue_scheduler_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [RS_DEPTH-1:0]          ent_valid,
    input  logic [RS_DEPTH-1:0]          ent_src1rdy,
    input  logic [RS_DEPTH-1:0]          ent_src2rdy,
    input  logic [2*RS_DEPTH-1:0]        ent_fu,
    input  logic [RS_IDX_W-1:0]          rob_head,
    input  logic [NUM_FU-1:0]            fu_rdy,
    input  logic                         flush,
    output logic [NUM_FU-1:0]            rdreq_valid,
    output logic [RS_IDX_W*NUM_FU-1:0]   rdreq_idx,
    output logic [NUM_FU-1:0]            iss_valid,
    output logic [RS_IDX_W*NUM_FU-1:0]   iss_idx,
    output logic [RS_DEPTH-1:0]          rs_clear
);

    logic [RS_DEPTH-1:0] r_pending;
    logic [NUM_FU-1:0]   r_iss_valid;
    logic [RS_IDX_W-1:0] r_iss_idx [NUM_FU];

    logic [RS_DEPTH-1:0] w_eligible;
    logic [RS_DEPTH-1:0] w_cand [NUM_FU];
    logic [NUM_FU-1:0]   w_found;
    logic [RS_IDX_W-1:0] w_win [NUM_FU];
    logic [NUM_FU-1:0]   w_accept;
    logic [NUM_FU-1:0]   w_load;
    logic [RS_DEPTH-1:0] w_pending_nxt;

    // Split eligible entries into per-FU candidate vectors; an entry matches only its own FU code.
    always_comb begin
        w_eligible = ent_valid & ent_src1rdy & ent_src2rdy & ~r_pending;
        for (int f = 0; f < NUM_FU; f++) begin
            w_cand[f] = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                w_cand[f][i] = w_eligible[i] & (ent_fu[2*i +: 2] == 2'(f));
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_sel
        oldest_select u_sel (
            .cand     (w_cand[f]),
            .rob_head (rob_head),
            .found    (w_found[f]),
            .idx      (w_win[f])
        );
    end

    // Handshake decode, read-port request, per-entry clears and next in-flight set.
    always_comb begin
        w_accept      = '0;
        w_load        = '0;
        rdreq_idx     = '0;
        rs_clear      = '0;
        w_pending_nxt = r_pending;
        for (int f = 0; f < NUM_FU; f++) begin
            w_accept[f] = r_iss_valid[f] & fu_rdy[f];
            w_load[f]   = w_found[f] & (~r_iss_valid[f] | w_accept[f]) & ~flush;
            if (w_load[f]) begin
                rdreq_idx[f*RS_IDX_W +: RS_IDX_W] = w_win[f];
            end
            if (w_accept[f] && !flush) begin
                rs_clear[r_iss_idx[f]] = 1'b1;
            end
            if (w_accept[f]) begin
                w_pending_nxt[r_iss_idx[f]] = 1'b0;
            end
        end
        // Sets come after clears: a squashed entry may reload while its old slot drains.
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_load[f]) begin
                w_pending_nxt[w_win[f]] = 1'b1;
            end
        end
        w_pending_nxt = w_pending_nxt & ent_valid;
    end

    assign rdreq_valid = w_load;
    assign iss_valid   = r_iss_valid;

    // Pack the slot indices onto the flat output bus.
    always_comb begin
        iss_idx = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            iss_idx[f*RS_IDX_W +: RS_IDX_W] = r_iss_idx[f];
        end
    end

    // Issue slots and in-flight bits; reset and flush drop everything without clearing the RS.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_pending   <= '0;
            r_iss_valid <= '0;
            // NOTE: the slot index array is only NUM_FU entries, so it is reset to give a defined value.
            for (int f = 0; f < NUM_FU; f++) begin
                r_iss_idx[f] <= '0;
            end
        end else if (flush) begin
            r_pending   <= '0;
            r_iss_valid <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            for (int f = 0; f < NUM_FU; f++) begin
                if (w_load[f]) begin
                    r_iss_valid[f] <= 1'b1;
                    r_iss_idx[f]   <= w_win[f];
                end else if (w_accept[f]) begin
                    r_iss_valid[f] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: directed stimulus pushes the expected
// issue order per FU; a monitor pops and compares on every FU accept and checks
// rs_clear every cycle. A small RS model drops entries the DUT clears.
module tb_issue_scheduler;
    import issue_scheduler_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [RS_DEPTH-1:0]         ent_valid;
    logic [RS_DEPTH-1:0]         ent_src1rdy;
    logic [RS_DEPTH-1:0]         ent_src2rdy;
    logic [2*RS_DEPTH-1:0]       ent_fu;
    logic [RS_IDX_W-1:0]         rob_head;
    logic [NUM_FU-1:0]           fu_rdy;
    logic                        flush;
    logic [NUM_FU-1:0]           rdreq_valid;
    logic [RS_IDX_W*NUM_FU-1:0]  rdreq_idx;
    logic [NUM_FU-1:0]           iss_valid;
    logic [RS_IDX_W*NUM_FU-1:0]  iss_idx;
    logic [RS_DEPTH-1:0]         rs_clear;

    always #5 clk = ~clk;

    issue_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .ent_valid   (ent_valid),
        .ent_src1rdy (ent_src1rdy),
        .ent_src2rdy (ent_src2rdy),
        .ent_fu      (ent_fu),
        .rob_head    (rob_head),
        .fu_rdy      (fu_rdy),
        .flush       (flush),
        .rdreq_valid (rdreq_valid),
        .rdreq_idx   (rdreq_idx),
        .iss_valid   (iss_valid),
        .iss_idx     (iss_idx),
        .rs_clear    (rs_clear)
    );

    int total = 0;
    int bad   = 0;
    int q0[$];
    int q1[$];
    int q2[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] fsl(input logic [11:0] v, input int f);
        return v[f*4 +: 4];
    endfunction

    task automatic push(input int f, input int v);
        case (f)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int f);
        case (f)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int pop_q(input int f);
        case (f)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every accepted slot must match the next expected entry for that FU,
    // and rs_clear must be exactly the one-hot OR of the accepted expected entries.
    initial begin
        logic [RS_DEPTH-1:0] exp_clr;
        int e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_clr = '0;
                for (int f = 0; f < NUM_FU; f++) begin
                    if (iss_valid[f] && fu_rdy[f] && !flush) begin
                        if (qsize(f) == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexp_issue fu%0d: got idx %0d expected none", f, fsl(iss_idx, f));
                        end else begin
                            e = pop_q(f);
                            check($sformatf("iss_idx fu%0d", f), 32'(fsl(iss_idx, f)), e);
                            exp_clr[e] = 1'b1;
                        end
                    end
                end
                check("rs_clear", 32'(rs_clear), 32'(exp_clr));
            end
        end
    end

    task automatic set_ent(input int i, input logic [1:0] fu);
        ent_valid[i]     = 1'b1;
        ent_src1rdy[i]   = 1'b1;
        ent_src2rdy[i]   = 1'b1;
        ent_fu[2*i +: 2] = fu;
    endtask

    task automatic clr_ent(input int i);
        ent_valid[i]   = 1'b0;
        ent_src1rdy[i] = 1'b0;
        ent_src2rdy[i] = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Move to just after the next edge; the RS model drops entries cleared at that edge.
    task automatic advance();
        logic [RS_DEPTH-1:0] clr;
        clr = rs_clear;
        @(posedge clk);
        #1;
        ent_valid = ent_valid & ~clr;
    endtask

    initial begin
        int first;
        int second;
        reset       = 1'b1;
        ent_valid   = '0;
        ent_src1rdy = '0;
        ent_src2rdy = '0;
        ent_fu      = '0;
        rob_head    = '0;
        fu_rdy      = '0;
        flush       = 1'b0;

        // Reset state
        sample();
        check("rst iss_valid", 32'(iss_valid), 0);
        check("rst iss_idx", 32'(iss_idx), 0);
        check("rst rdreq_valid", 32'(rdreq_valid), 0);
        check("rst rs_clear", 32'(rs_clear), 0);
        advance();
        reset = 1'b0;
        sample();
        check("idle iss_valid", 32'(iss_valid), 0);
        check("idle rdreq_idx", 32'(rdreq_idx), 0);
        advance();

        // Single entry 5 on ALU0: same-cycle read request, issue and clear next cycle
        set_ent(5, FU_ALU0);
        fu_rdy = 3'b111;
        push(0, 5);
        sample();
        check("t1 rdreq_valid", 32'(rdreq_valid), 32'b001);
        check("t1 rdreq_idx0", 32'(fsl(rdreq_idx, 0)), 5);
        advance();
        sample();
        check("t1 iss_valid", 32'(iss_valid), 32'b001);
        check("t1 iss_idx0", 32'(fsl(iss_idx, 0)), 5);
        check("t1 rs_clear", 32'(rs_clear), 32'h20);
        advance();
        sample();
        check("t1 drained", 32'(iss_valid), 0);
        advance();

        // Entries 2 and 14 on MEM with rob_head=10: pick order depends on age ordering
`ifdef ISSUE_AGE_ORDER_EN
        first  = 14;
        second = 2;
`else
        first  = 2;
        second = 14;
`endif
        rob_head = 4'd10;
        set_ent(2, FU_MEM);
        set_ent(14, FU_MEM);
        push(2, first);
        push(2, second);
        sample();
        check("t2 rdreq_idx2 first", 32'(fsl(rdreq_idx, 2)), first);
        advance();
        sample();
        check("t2 iss_idx2 first", 32'(fsl(iss_idx, 2)), first);
        check("t2 rdreq_idx2 second", 32'(fsl(rdreq_idx, 2)), second);
        advance();
        sample();
        check("t2 iss_idx2 second", 32'(fsl(iss_idx, 2)), second);
        advance();
        sample();
        check("t2 drained", 32'(iss_valid), 0);
        advance();
        rob_head = '0;

        // MEM holds entry 7 for 4 cycles while ALU0 keeps issuing 10 then 11
        set_ent(7, FU_MEM);
        set_ent(10, FU_ALU0);
        set_ent(11, FU_ALU0);
        fu_rdy = 3'b001;
        push(2, 7);
        push(0, 10);
        push(0, 11);
        sample();
        check("t3 rdreq_valid", 32'(rdreq_valid), 32'b101);
        check("t3 rdreq_idx0", 32'(fsl(rdreq_idx, 0)), 10);
        check("t3 rdreq_idx2", 32'(fsl(rdreq_idx, 2)), 7);
        advance();
        for (int c = 0; c < 4; c++) begin
            sample();
            check("t3 hold valid2", 32'(iss_valid[2]), 1);
            check("t3 hold idx2", 32'(fsl(iss_idx, 2)), 7);
            check("t3 no reselect", 32'(rdreq_valid[2]), 0);
            if (c == 1) check("t3 alu0 idx", 32'(fsl(iss_idx, 0)), 11);
            advance();
        end
        fu_rdy = 3'b111;
        sample();
        advance();
        sample();
        check("t3 drained", 32'(iss_valid), 0);
        advance();

        // ALU1 back-to-back 1, 3, 4; entry 2 with src2 not ready stays put
        set_ent(1, FU_ALU1);
        set_ent(3, FU_ALU1);
        set_ent(4, FU_ALU1);
        set_ent(2, FU_ALU1);
        ent_src2rdy[2] = 1'b0;
        push(1, 1);
        push(1, 3);
        push(1, 4);
        sample();
        check("t4 rdreq_idx1", 32'(fsl(rdreq_idx, 1)), 1);
        advance();
        sample();
        check("t4 c1 idx1", 32'(fsl(iss_idx, 1)), 1);
        advance();
        sample();
        check("t4 c2 valid1", 32'(iss_valid[1]), 1);
        check("t4 c2 idx1", 32'(fsl(iss_idx, 1)), 3);
        advance();
        sample();
        check("t4 c3 valid1", 32'(iss_valid[1]), 1);
        check("t4 c3 idx1", 32'(fsl(iss_idx, 1)), 4);
        advance();
        sample();
        check("t4 src2 blocks", 32'(rdreq_valid), 0);
        advance();
        clr_ent(2);

        // Flush with ALU0=0 and MEM=9 held; both re-picked after flush drops
        set_ent(0, FU_ALU0);
        set_ent(9, FU_MEM);
        fu_rdy = 3'b000;
        push(0, 0);
        push(2, 9);
        sample();
        check("t5 rdreq_valid", 32'(rdreq_valid), 32'b101);
        advance();
        sample();
        check("t5 held", 32'(iss_valid), 32'b101);
        advance();
        flush  = 1'b1;
        fu_rdy = 3'b111;
        sample();
        check("t5 flush rdreq", 32'(rdreq_valid), 0);
        advance();
        flush  = 1'b0;
        fu_rdy = 3'b000;
        sample();
        check("t5 post flush valid", 32'(iss_valid), 0);
        check("t5 repick", 32'(rdreq_valid), 32'b101);
        check("t5 repick idx2", 32'(fsl(rdreq_idx, 2)), 9);
        advance();
        sample();
        check("t5 reissued", 32'(iss_valid), 32'b101);
        check("t5 reissued idx2", 32'(fsl(iss_idx, 2)), 9);
        advance();
        fu_rdy = 3'b111;
        sample();
        advance();
        sample();
        check("t5 drained", 32'(iss_valid), 0);
        advance();

        // Reserved FU code 3 on entry 6 is never picked
        set_ent(6, 2'd3);
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t6 no rdreq", 32'(rdreq_valid), 0);
            check("t6 no issue", 32'(iss_valid), 0);
            advance();
        end
        clr_ent(6);

        // Entry 8 squashed while held: pending clears, so it reloads as the slot drains
        set_ent(8, FU_ALU0);
        fu_rdy = 3'b000;
        push(0, 8);
        push(0, 8);
        sample();
        check("t7 rdreq0", 32'(rdreq_valid[0]), 1);
        advance();
        sample();
        check("t7 held idx0", 32'(fsl(iss_idx, 0)), 8);
        advance();
        ent_valid[8] = 1'b0;
        sample();
        check("t7 still held", 32'(iss_valid[0]), 1);
        advance();
        set_ent(8, FU_ALU0);
        sample();
        check("t7 slot full", 32'(rdreq_valid[0]), 0);
        advance();
        fu_rdy = 3'b001;
        sample();
        check("t7 reload valid", 32'(rdreq_valid[0]), 1);
        check("t7 reload idx", 32'(fsl(rdreq_idx, 0)), 8);
        advance();
        sample();
        check("t7 second issue", 32'(iss_valid[0]), 1);
        advance();
        sample();
        check("t7 drained", 32'(iss_valid), 0);
        advance();

        repeat (2) begin
            sample();
            advance();
        end
        for (int f = 0; f < NUM_FU; f++) begin
            check($sformatf("leftover fu%0d", f), 32'(qsize(f)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Per-cycle issue scheduler for the 16-entry reservation station: picks at most one ready entry for each of the three functional units (ALU0, ALU1, MEM), drives the register-file read-port index for each pick, and holds a registered issue slot per FU under a valid/ready handshake. It sits between the RS table, which supplies entry status and receives per-entry clears, and the FU issue registers. It owns the "in flight" bookkeeping so that an entry is never picked twice.

## Interface
- RS_DEPTH, 16, RS entries; entry index equals ROB number
- IDX_W, 4, log2(RS_DEPTH)
- NUM_FU, 3, FU count; FU 0 = ALU0, 1 = ALU1, 2 = MEM
- clk  in  1  sole clock; all state on posedge
- reset  in  1  synchronous, active-high
- ent_valid  in  RS_DEPTH  RS entry valid
- ent_src1rdy  in  RS_DEPTH  source 1 ready
- ent_src2rdy  in  RS_DEPTH  source 2 ready (RS forces 1 for immediates)
- ent_fu  in  2*RS_DEPTH  FU code per entry, entry i at [2i+1:2i]; code 3 is reserved and never selected
- rob_head  in  IDX_W  ROB number of the oldest in-flight instruction
- fu_rdy  in  NUM_FU  FU accepts its issue slot this cycle
- flush  in  1  discard all slots and pending state
- rdreq_valid  out  NUM_FU  combinational; slot f loads this cycle
- rdreq_idx  out  IDX_W*NUM_FU  combinational; entry index being loaded, which drives the regfile read mux
- iss_valid  out  NUM_FU  registered; slot f holds an issue
- iss_idx  out  IDX_W*NUM_FU  registered; entry index in slot f
- rs_clear  out  RS_DEPTH  combinational; one-hot per accepted slot, OR-ed across FUs; the RS invalidates these entries at this edge

## Operation
- eligible[i] = ent_valid[i] & ent_src1rdy[i] & ent_src2rdy[i] & ~pending[i].
- cand_f = eligible & (ent_fu == f). Exactly one winner per FU, chosen by priority (see Configuration). A single entry is a candidate for one FU only.
- accept_f = iss_valid[f] & fu_rdy[f].
- load_f = |cand_f & (~iss_valid[f] | accept_f) & ~flush. On load, the slot captures the winner and pending[winner] is set.
- accept_f with no load: iss_valid[f] clears. accept_f asserts rs_clear[iss_idx_f] and clears pending[iss_idx_f] at the same edge.
- An accept and a load on the same FU in the same cycle are legal, giving one issue per cycle per FU.
- Slot held with fu_rdy[f]=0: iss_idx_f is stable and no rs_clear is driven. Other FUs are unaffected.
- pending[i] self-clears when ent_valid[i]=0, which covers an external squash of a held entry.
- flush: all iss_valid, pending and rdreq_valid go to 0 next edge, and rs_clear is forced to 0 in the flush cycle.
- No entries eligible: rdreq_valid=0; rdreq_idx is don't-care but held at 0.

## Timing
- Reset values: iss_valid=0, iss_idx=0, pending=0; combinational outputs evaluate to 0.
- Eligible in cycle N, slot empty: rdreq_valid in N, iss_valid from N+1.
- Issue-to-clear: rs_clear is asserted in the cycle the FU accepts, and the entry is gone from the RS at the following edge.
- Minimum RS-residency-to-issue is 1 cycle after ready status appears at the inputs.
- Reset or flush asserted mid-hold drops the slot with no rs_clear; the RS owns re-dispatch.
- rob_head is sampled combinationally, so a head change takes effect in the same cycle.

## Configuration
- ISSUE_AGE_ORDER_EN defined: the winner is the candidate with minimum age, where age = (i - rob_head) mod RS_DEPTH using an unsigned IDX_W-bit wrap subtract. Oldest goes first.
- Not defined: the winner is the lowest-index candidate, and rob_head is ignored.

## Structure
- Shared package typedefs: fu_e enum {FU_ALU0=0, FU_ALU1=1, FU_MEM=2}, plus RS_DEPTH and RS_IDX_W constants.
- Sub-module oldest_select(cand, rob_head) -> {found, idx}, holding the ISSUE_AGE_ORDER_EN mux. Instantiated NUM_FU times.

## Test plan
- Reset, then entry 5 valid and ready with FU_ALU0, fu_rdy=3'b111 -> rdreq_idx0=5 in the same cycle, iss_valid=001/iss_idx0=5 next cycle, rs_clear=1<<5 in that cycle.
- Entries 2 and 14 ready on MEM, rob_head=10, with macro -> 14 issues first, then 2. Without macro -> 2 first.
- MEM slot holds entry 7, fu_rdy[2]=0 for 4 cycles -> iss_idx2=7 is stable, rs_clear=0, and entry 7 is not reselected. ALU0 keeps issuing.
- Entries 1, 3, 4 on ALU1, fu_rdy=1 -> back-to-back iss_idx1 1, 3, 4 over 3 consecutive cycles with no bubble.
- Slots ALU0=0 and MEM=9 held, flush=1 -> next cycle iss_valid=000 with no rs_clear. Entry 9 still valid is picked again 1 cycle after flush deasserts.
- ent_fu=3 on entry 6 (ready) -> never issued. ent_valid[8] dropped while slot holds 8 -> pending[8] cleared.
